// File: rtl/ahb_lite_ram_ws.sv
// ahb_lite_ram_ws: AHB-Lite slave on word-organised RAM with WAIT_STATES wait states per data phase.
// Define AHB_LITE_RAM_ERR_EN for range/size/alignment checks with a two-cycle ERROR response.
module ahb_lite_ram_ws #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
`ifdef AHB_LITE_RAM_ERR_EN
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t               state, state_nx;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] a_word, h_word, ld_word;
    logic [3:0]           a_be, h_be;
    logic                 a_write;
    logic                 accept, err, last, wr_en, ld_en;
    logic [31:0]          rd_word;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
    logic                 unused_ok;

    assign unused_ok = ^{HBURST, HTRANS[0], HADDR};

    always_comb begin
        h_word  = HADDR[ADDR_BITS+1:2];
        h_be    = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] :
                  HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        accept  = HSEL & HTRANS[1] & HREADY;
`ifdef AHB_LITE_RAM_ERR_EN
        err     = (|HADDR[31:ADDR_BITS+2]) | (HSIZE > 3'd2) | (HSIZE == 3'd1 & HADDR[0]) |
                  (HSIZE == 3'd2 & (|HADDR[1:0]));
`else
        err     = 1'b0;
`endif
        last    = state == DATA && cnt == 4'd0;
        wr_en   = last & a_write;
        // zero-wait reads must sample the RAM while the address phase is still on the bus
        ld_en   = WS == 4'd0 ? accept & ~err & ~HWRITE : state == DATA && cnt == 4'd1 && !a_write;
        ld_word = WS == 4'd0 ? h_word : a_word;
        rd_word = mem[ld_word];
        for (int i = 0; i < 4; i++)
            if (wr_en && a_word == ld_word && a_be[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
`ifdef AHB_LITE_RAM_ERR_EN
        state_nx = accept ? (err ? ERR1 : DATA) :
                   state == DATA && cnt != 4'd0 ? DATA :
                   state == ERR1 ? ERR2 : IDLE;
`else
        state_nx = accept ? DATA : state == DATA && cnt != 4'd0 ? DATA : IDLE;
`endif
    end

    always_comb begin
`ifdef AHB_LITE_RAM_ERR_EN
        HREADY = state == IDLE || state == ERR2 || last;
        HRESP  = state == ERR1 || state == ERR2;
`else
        HREADY = state == IDLE || last;
        HRESP  = 1'b0;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            cnt     <= 4'd0;
            a_word  <= '0;
            a_be    <= 4'd0;
            a_write <= 1'b0;
            HRDATA  <= 32'd0;
        end else begin
            if (accept) begin
                cnt     <= WS;
                a_word  <= h_word;
                a_be    <= h_be;
                a_write <= HWRITE;
            end else if (state == DATA && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (ld_en) HRDATA <= rd_word;
        end

    // RAM contents survive reset; a write pending at reset never reaches here since state is IDLE
    always_ff @(posedge HCLK)
        for (int i = 0; i < 4; i++)
            if (wr_en && a_be[i]) mem[a_word][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule

// File: tb/tb_ahb_lite_ram_ws.sv
// tb_ahb_lite_ram_ws: directed vectors for ahb_lite_ram_ws, u0 with two wait states, u1 with none.
module tb_ahb_lite_ram_ws;
    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ex;
        logic        chk;
        int          waits;
        logic        resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [2:0]  hsize [2];
    logic [1:0]  htrans [2];
    logic        hsel [2];
    logic        hwrite [2];
    logic [31:0] hrdata0, hrdata1;
    logic        hready0, hready1, hresp0, hresp1;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs [$];

    always #5 clk = ~clk;

    ahb_lite_ram_ws #(.ADDR_BITS(10), .WAIT_STATES(2)) u0 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr[0]), .HBURST(3'b000), .HSEL(hsel[0]),
        .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HWRITE(hwrite[0]),
        .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
    );

    ahb_lite_ram_ws #(.ADDR_BITS(10), .WAIT_STATES(0)) u1 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr[1]), .HBURST(3'b000), .HSEL(hsel[1]),
        .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HWRITE(hwrite[1]),
        .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ex, input logic chk,
                       input int waits, input logic resp);
        vec_t v;
        v.name = nm; v.w = w; v.sz = sz; v.a = a; v.wd = wd; v.ex = ex;
        v.chk = chk; v.waits = waits; v.resp = resp;
        vecs.push_back(v);
    endtask

    task automatic bus_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; haddr[d] = 32'd0; hsize[d] = 3'd0;
    endtask

    // one non-pipelined transfer; starts and ends just after a rising edge with the slave ready
    task automatic xfer(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits,
                        output logic resp);
        hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = w; hsize[d] = sz; haddr[d] = a;
        @(posedge clk); #1;
        bus_idle(d);
        hwdata[d] = wd;
        waits = 0;
        @(negedge clk);
        while (!(d == 1 ? hready1 : hready0) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        rd   = d == 1 ? hrdata1 : hrdata0;
        resp = d == 1 ? hresp1 : hresp0;
        @(posedge clk); #1;
    endtask

    // write immediately followed by a read on the zero-wait instance
    task automatic pipe_wr_rd(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                              input logic [31:0] exp, input string nm);
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = wa;
        @(posedge clk); #1;
        hwdata[1] = wd; hwrite[1] = 1'b0; haddr[1] = ra;
        @(negedge clk);
        check({nm, "_wr_ready"}, {31'd0, hready1}, 32'd1);
        @(posedge clk); #1;
        bus_idle(1);
        @(negedge clk);
        check({nm, "_rd_ready"}, {31'd0, hready1}, 32'd1);
        check({nm, "_rdata"}, hrdata1, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          waits;
        logic        resp;

        add("wr_w4",   1'b1, 3'd2, 32'h4,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b0);
        add("rd_w4",   1'b0, 3'd2, 32'h4,  32'h0,        32'hDEADBEEF, 1'b1, 2, 1'b0);
        add("wr_w8",   1'b1, 3'd2, 32'h8,  32'h00000000, 32'h0,        1'b0, 2, 1'b0);
        add("wr_b6",   1'b1, 3'd0, 32'h6,  32'h00550000, 32'h0,        1'b0, 2, 1'b0);
        add("wr_h8",   1'b1, 3'd1, 32'h8,  32'h00001234, 32'h0,        1'b0, 2, 1'b0);
        add("rd_w4b",  1'b0, 3'd2, 32'h4,  32'h0,        32'hDE55BEEF, 1'b1, 2, 1'b0);
        add("rd_w8",   1'b0, 3'd2, 32'h8,  32'h0,        32'h00001234, 1'b1, 2, 1'b0);
        add("wr_ha",   1'b1, 3'd1, 32'hA,  32'hABCD0000, 32'h0,        1'b0, 2, 1'b0);
        add("wr_bb",   1'b1, 3'd0, 32'hB,  32'h77000000, 32'h0,        1'b0, 2, 1'b0);
        add("rd_w8b",  1'b0, 3'd2, 32'h8,  32'h0,        32'h77CD1234, 1'b1, 2, 1'b0);
        add("wr_w0",   1'b1, 3'd2, 32'h0,  32'hCAFEF00D, 32'h0,        1'b0, 2, 1'b0);
`ifdef AHB_LITE_RAM_ERR_EN
        add("err_rd2", 1'b0, 3'd2, 32'h2,    32'h0,        32'h0,        1'b0, 1, 1'b1);
        add("err_wr_1000", 1'b1, 3'd2, 32'h1000, 32'hBAD0BAD0, 32'h0,   1'b0, 1, 1'b1);
        add("rd_w0",   1'b0, 3'd2, 32'h0,    32'h0,        32'hCAFEF00D, 1'b1, 2, 1'b0);
        add("err_h1",  1'b1, 3'd1, 32'h1,    32'h0000FFFF, 32'h0,        1'b0, 1, 1'b1);
        add("err_sz3", 1'b1, 3'd3, 32'h0,    32'h00000000, 32'h0,        1'b0, 1, 1'b1);
        add("rd_w0b",  1'b0, 3'd2, 32'h0,    32'h0,        32'hCAFEF00D, 1'b1, 2, 1'b0);
`else
        add("wr_b1000", 1'b1, 3'd0, 32'h1000, 32'h00000011, 32'h0,       1'b0, 2, 1'b0);
        add("rd_w0",   1'b0, 3'd2, 32'h0,    32'h0,        32'hCAFEF011, 1'b1, 2, 1'b0);
        add("wr_h9",   1'b1, 3'd1, 32'h9,    32'h0000BEEF, 32'h0,        1'b0, 2, 1'b0);
        add("rd_w8c",  1'b0, 3'd2, 32'h8,    32'h0,        32'h77CDBEEF, 1'b1, 2, 1'b0);
        add("wr_we",   1'b1, 3'd2, 32'hE,    32'h0BADF00D, 32'h0,        1'b0, 2, 1'b0);
        add("rd_wc",   1'b0, 3'd2, 32'hC,    32'h0,        32'h0BADF00D, 1'b1, 2, 1'b0);
        add("wr_sz3",  1'b1, 3'd3, 32'h10,   32'h31415926, 32'h0,        1'b0, 2, 1'b0);
        add("rd_w10",  1'b0, 3'd2, 32'h10,   32'h0,        32'h31415926, 1'b1, 2, 1'b0);
`endif

        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            hwdata[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hready0", {31'd0, hready0}, 32'd1);
        check("rst_hresp0",  {31'd0, hresp0},  32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hready1", {31'd0, hready1}, 32'd1);
        check("rst_hrdata1", hrdata1, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            xfer(0, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, rd, waits, resp);
            check({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].waits));
            check({vecs[i].name, "_resp"}, {31'd0, resp}, {31'd0, vecs[i].resp});
            if (vecs[i].chk) check({vecs[i].name, "_rdata"}, rd, vecs[i].ex);
        end

        // IDLE, BUSY and unselected NONSEQ must neither stall nor write
        hsel[0] = 1'b1; htrans[0] = 2'b00; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h4;
        hwdata[0] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("noacc_hready", {31'd0, hready0}, 32'd1);
            check("noacc_hresp",  {31'd0, hresp0},  32'd0);
            @(posedge clk); #1;
            hwdata[0] = 32'h0;
            if (k == 0) htrans[0] = 2'b01;
            if (k == 1) begin hsel[0] = 1'b0; htrans[0] = 2'b10; end
        end
        bus_idle(0);
        xfer(0, 1'b0, 3'd2, 32'h4, 32'h0, rd, waits, resp);
        check("noacc_rd_w4", rd, 32'hDE55BEEF);

        pipe_wr_rd(32'h10, 32'hA5A5A5A5, 32'h10, 32'hA5A5A5A5, "fwd_same");
        pipe_wr_rd(32'h14, 32'h11112222, 32'h10, 32'hA5A5A5A5, "fwd_other");
        xfer(1, 1'b0, 3'd2, 32'h14, 32'h0, rd, waits, resp);
        check("ws0_rd14_waits", 32'(waits), 32'd0);
        check("ws0_rd14_rdata", rd, 32'h11112222);

        xfer(0, 1'b1, 3'd2, 32'h20, 32'h13579BDF, rd, waits, resp);
        xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, waits, resp);
        check("pre_rst_rd20", rd, 32'h13579BDF);
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h20;
        @(posedge clk); #1;
        bus_idle(0);
        hwdata[0] = 32'h2468ACE0;
        @(negedge clk);
        check("midrst_wait_hready", {31'd0, hready0}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hready", {31'd0, hready0}, 32'd1);
        check("midrst_hresp",  {31'd0, hresp0},  32'd0);
        check("midrst_hrdata", hrdata0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, waits, resp);
        check("post_rst_waits", 32'(waits), 32'd2);
        check("post_rst_rd20", rd, 32'h13579BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
